exec_unit: RTL and testbench
============================

# exec_unit

Parametrised execute unit for the WIDTH-bit datapath. It takes decoded ALU operation codes, registered operands and an immediate, and selects the B operand internally. Single-cycle logic, compare and shift operations complete in one cycle; a signed multiply runs iteratively over WIDTH cycles. Operations enter and results leave through a valid/ready handshake, so the multi-cycle op can stall the issuing stage.

## Interface
- WIDTH, 16, datapath width in bits (power of two, ≥8)
- PC_INC, 2, constant driven on B when In_SrcB = 1
- CLK  input  1  rising-edge clock; the only clock
- Reset  input  1  asynchronous, active-high; clears all state
- In_Flush  input  1  synchronous abort of the in-flight op
- In_Valid  input  1  operation request
- Out_Ready  output  1  unit can accept this cycle
- In_Op  input  4  operation code
- In_A  input  WIDTH  operand A, signed
- In_B  input  WIDTH  operand B, signed
- In_Imm  input  WIDTH  sign-extended immediate
- In_SrcB  input  2  B select: 0 In_B, 1 PC_INC, 2 In_Imm, 3 zero
- Out_Valid  output  1  result valid, single-cycle pulse
- Out_Result  output  WIDTH  result, signed
- Out_Zero  output  1  Out_Result == 0
- Out_Overflow  output  1  signed overflow (ADD/SUB/MUL only, else 0)

## Operation
- B operand: Bsel = mux(In_SrcB) over In_B, PC_INC, In_Imm, 0.
- Op codes:
  - 0 ADD: A+Bsel
  - 1 SUB: A−Bsel
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOR
  - 6 SLT: signed A<Bsel → 1, else 0
  - 7 SLTU: same compare, unsigned
  - 8 SLL
  - 9 SRL
  - 10 SRA
  - 11 MUL
  - 12–15: result 0, no flags
- Shifts use only the low log2(WIDTH) bits of Bsel as the shift amount. SRA fills with A's MSB.
- ADD/SUB arithmetic: modulo 2^WIDTH. Overflow = operand signs agree (for SUB, A and ~Bsel) and result sign differs.
- MUL:
  - Out_Result = low WIDTH bits of the signed product A×Bsel.
  - Overflow = 1 when the full 2·WIDTH signed product lies outside the signed WIDTH range.
  - Implemented as iterative shift-add, one partial-product step per cycle. No combinational multiplier.
- FSM states:
  - IDLE: Out_Ready = 1.
    - Accept when In_Valid & Out_Ready.
    - Non-MUL op: compute, register the result, stay in IDLE.
    - MUL: latch operands, load counter = WIDTH, go to MUL.
  - MUL: Out_Ready = 0. Decrement the counter each cycle; at counter = 1, register the result and go to IDLE.
- Requests with In_Valid while Out_Ready = 0 are ignored. They are not queued; the issuer must hold them.
- Out_Result, Out_Zero and Out_Overflow hold their last values until the next completion. Only Out_Valid pulses.
- In_Flush:
  - In MUL: return to IDLE, no Out_Valid, result registers unchanged.
  - In IDLE: suppresses any accept in the same cycle.
  - Flush takes priority over accept and over completion.
- Reset (asynchronous, any time, including mid-MUL):
  - Out_Result = 0, Out_Zero = 1, Out_Overflow = 0, Out_Valid = 0.
  - State = IDLE, so Out_Ready = 1 while Reset is held and after release.

## Timing
- Out_Ready is decoded from state only. It never depends on In_Valid.
- Non-MUL op accepted at edge k: Out_Valid = 1 for exactly the cycle after edge k, with the result registered at edge k.
- Back-to-back single-cycle ops: one accept and one result per cycle, with no bubble.
- MUL accepted at edge k:
  - Out_Ready = 0 from after edge k until edge k+WIDTH.
  - Result registered at edge k+WIDTH; Out_Valid high and Out_Ready = 1 in the cycle after edge k+WIDTH.
  - A new op may be accepted at edge k+WIDTH+1. MUL throughput is one per WIDTH+1 cycles.
- Out_Zero and Out_Overflow update on the same edge as Out_Result.
- Reset deassertion is synchronised by the system. The first accept may occur on the first edge after release.

## Test plan
- ADD, A=0x7FFF, In_SrcB=0, B=0x0001 → Result 0x8000, Overflow=1, Zero=0. Out_Valid pulses one cycle after accept.
- SUB, A=0x0005, In_SrcB=2, Imm=0x0005 → Result 0x0000, Zero=1, Overflow=0. Then ADD, A=0x0100, In_SrcB=1 → Result 0x0102 on the next cycle (back-to-back, no bubble).
- Shifts:
  - SRA, A=0x8000, B=0x0004 → 0xF800.
  - SLL, A=0x0001, B=0x0013 (amount 3) → 0x0008.
  - SLTU, A=0xFFFF, B=0x0001 → 0.
  - SLT, same operands → 1.
- MUL, A=0xFFFD (−3), B=0x0007:
  - Out_Ready=0 for 16 cycles; In_Valid pulses during busy are ignored.
  - Result 0xFFEB, Overflow=0, Out_Valid 16 cycles after the accept edge.
- MUL, A=300, B=300 → Result 0x5F90, Overflow=1. A following MUL, A=0, B=0x1234 → Result 0, Zero=1.
- Abort mid-MUL:
  - Reset at cycle 5 → immediately Result 0, Zero=1, Ready=1, no Out_Valid.
  - In_Flush at cycle 5 → no Out_Valid; previous Result held; Ready=1 next cycle.
  - Flush and In_Valid together in IDLE → no accept.

Source files
------------

// File: rtl/exec_unit.sv
// Execute unit: single-cycle ALU ops plus an iterative signed shift-add multiplier,
// fronted by a valid/ready handshake so the multiply can stall the issuing stage.
module exec_unit #(
  parameter int WIDTH  = 16,
  parameter int PC_INC = 2
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             In_Flush,
  input  logic             In_Valid,
  output logic             Out_Ready,
  input  logic [3:0]       In_Op,
  input  logic [WIDTH-1:0] In_A,
  input  logic [WIDTH-1:0] In_B,
  input  logic [WIDTH-1:0] In_Imm,
  input  logic [1:0]       In_SrcB,
  output logic             Out_Valid,
  output logic [WIDTH-1:0] Out_Result,
  output logic             Out_Zero,
  output logic             Out_Overflow
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;
  localparam int PW  = 2 * WIDTH;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;

  logic [WIDTH-1:0] bsel;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;
  logic             accept, last;
  logic [PW-1:0]    addend, acc_step;
  logic             mul_ovf;

  assign Out_Ready = (state == S_IDLE);
  assign accept    = Out_Ready && In_Valid && !In_Flush;

  always_comb begin
    unique case (In_SrcB)
      2'd0:    bsel = In_B;
      2'd1:    bsel = WIDTH'(PC_INC);
      2'd2:    bsel = In_Imm;
      default: bsel = '0;
    endcase
  end

  assign shamt = bsel[SHW-1:0];
  assign sum   = In_A + bsel;
  assign diff  = In_A - bsel;

  // NOTE: every variable written in a combinational block gets a default first,
  // so no path through the case statement can infer a latch.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (In_Op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (In_A[WIDTH-1] == bsel[WIDTH-1]) && (sum[WIDTH-1] != In_A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (In_A[WIDTH-1] != bsel[WIDTH-1]) && (diff[WIDTH-1] != In_A[WIDTH-1]);
      end
      OP_AND:  alu_res = In_A & bsel;
      OP_OR:   alu_res = In_A | bsel;
      OP_XOR:  alu_res = In_A ^ bsel;
      OP_NOR:  alu_res = ~(In_A | bsel);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(In_A) < $signed(bsel))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (In_A < bsel)};
      OP_SLL:  alu_res = In_A << shamt;
      OP_SRL:  alu_res = In_A >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(In_A) >>> shamt);
      default: ;
    endcase
  end

  // The multiplier's sign bit carries negative weight, so the final step subtracts.
  assign last     = (cnt == CW'(1));
  assign addend   = mplier[0] ? mcand : '0;
  assign acc_step = last ? (acc - addend) : (acc + addend);
  assign mul_ovf  = !((&acc_step[PW-1:WIDTH-1]) || ~(|acc_step[PW-1:WIDTH-1]));

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (accept && In_Op == OP_MUL) state_next = S_MUL;
      S_MUL:  if (In_Flush || last)          state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cnt          <= '0;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      Out_Valid    <= 1'b0;
      Out_Result   <= '0;
      Out_Zero     <= 1'b1;
      Out_Overflow <= 1'b0;
    end else begin
      Out_Valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            if (In_Op == OP_MUL) begin
              mcand  <= {{WIDTH{In_A[WIDTH-1]}}, In_A};
              mplier <= bsel;
              acc    <= '0;
              cnt    <= CW'(WIDTH);
            end else begin
              Out_Valid    <= 1'b1;
              Out_Result   <= alu_res;
              Out_Zero     <= (alu_res == '0);
              Out_Overflow <= alu_ovf;
            end
          end
        end
        S_MUL: begin
          if (!In_Flush) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (last) begin
              Out_Valid    <= 1'b1;
              Out_Result   <= acc_step[WIDTH-1:0];
              Out_Zero     <= (acc_step[WIDTH-1:0] == '0);
              Out_Overflow <= mul_ovf;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: directed cases from the test plan followed by
// randomized ops, all checked against a plain-arithmetic reference model.
module tb_exec_unit;

  localparam int W = 16;
  localparam longint MAXS = 32767;
  localparam longint MINS = -32768;

  logic         CLK = 1'b0;
  logic         Reset = 1'b1;
  logic         In_Flush = 1'b0;
  logic         In_Valid = 1'b0;
  logic         Out_Ready;
  logic [3:0]   In_Op = '0;
  logic [W-1:0] In_A = '0, In_B = '0, In_Imm = '0;
  logic [1:0]   In_SrcB = '0;
  logic         Out_Valid;
  logic [W-1:0] Out_Result;
  logic         Out_Zero, Out_Overflow;

  exec_unit #(.WIDTH(W), .PC_INC(2)) dut (
    .CLK(CLK), .Reset(Reset), .In_Flush(In_Flush), .In_Valid(In_Valid),
    .Out_Ready(Out_Ready), .In_Op(In_Op), .In_A(In_A), .In_B(In_B),
    .In_Imm(In_Imm), .In_SrcB(In_SrcB), .Out_Valid(Out_Valid),
    .Out_Result(Out_Result), .Out_Zero(Out_Zero), .Out_Overflow(Out_Overflow)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] model_last = '0;
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  function automatic logic [W-1:0] pick_b(input logic [1:0] srcb, input logic [W-1:0] b, input logic [W-1:0] imm);
    case (srcb)
      2'd0:    return b;
      2'd1:    return W'(2);
      2'd2:    return imm;
      default: return '0;
    endcase
  endfunction

  function automatic exp_t ref_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb_, ua, ub, r;
    bit     ov;
    int     sh;
    sa = $signed(a); sb_ = $signed(b); ua = a; ub = b;
    r = 0; ov = 0; sh = int'(b) % W;
    case (op)
      4'd0:  begin r = sa + sb_; ov = (r > MAXS) || (r < MINS); end
      4'd1:  begin r = sa - sb_; ov = (r > MAXS) || (r < MINS); end
      4'd2:  r = ua & ub;
      4'd3:  r = ua | ub;
      4'd4:  r = ua ^ ub;
      4'd5:  r = ~(ua | ub);
      4'd6:  r = (sa < sb_) ? 1 : 0;
      4'd7:  r = (ua < ub) ? 1 : 0;
      4'd8:  r = ua << sh;
      4'd9:  r = ua >> sh;
      4'd10: r = sa >>> sh;
      4'd11: begin r = sa * sb_; ov = (r > MAXS) || (r < MINS); end
      default: r = 0;
    endcase
    e.res  = r[W-1:0];
    e.zero = (e.res == '0);
    e.ovf  = ov;
    e.cyc  = 0;
    return e;
  endfunction

  // Monitor: every result the DUT presents must match the oldest pending expectation.
  always @(negedge CLK) begin
    if (!Reset && Out_Valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(Out_Valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result",   32'(Out_Result),   32'(e.res));
        check("zero",     32'(Out_Zero),     32'(e.zero));
        check("overflow", 32'(Out_Overflow), 32'(e.ovf));
        check("latency",  32'(cyc),          32'(e.cyc));
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] imm, input logic [1:0] srcb);
    In_Op = op; In_A = a; In_B = b; In_Imm = imm; In_SrcB = srcb; In_Valid = 1'b1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!Out_Ready && n < 100) begin @(posedge CLK); #1; n++; end
    if (!Out_Ready) check("ready_timeout", 32'(Out_Ready), 32'd1);
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge with In_Valid low.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] imm, input logic [1:0] srcb);
    exp_t e;
    drive(op, a, b, imm, srcb);
    wait_ready();
    e = ref_model(op, a, pick_b(srcb, b, imm));
    @(posedge CLK); #1;
    e.cyc = cyc + ((op == 4'd11) ? W : 0);
    sb.push_back(e);
    model_last = e.res;
    In_Valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge CLK); #1; n++; end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge CLK); #1;
  endtask

  task automatic start_unchecked_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    drive(4'd11, a, b, '0, 2'd0);
    wait_ready();
    @(posedge CLK); #1;
    In_Valid = 1'b0;
  endtask

  function automatic logic [W-1:0] corner();
    case ($urandom_range(0, 7))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0000;
      4: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    // Reset held: outputs at reset values, unit ready.
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ready",  32'(Out_Ready),    32'd1);
    check("rst_result", 32'(Out_Result),   32'd0);
    check("rst_zero",   32'(Out_Zero),     32'd1);
    check("rst_ovf",    32'(Out_Overflow), 32'd0);
    check("rst_valid",  32'(Out_Valid),    32'd0);
    Reset = 1'b0;

    // ADD overflow, then SUB-to-zero followed back-to-back by ADD with PC_INC.
    issue(4'd0, 16'h7FFF, 16'h0001, '0, 2'd0);
    check("add_res", 32'(Out_Result), 32'h8000);
    check("add_ovf", 32'(Out_Overflow), 32'd1);
    issue(4'd1, 16'h0005, 16'h1234, 16'h0005, 2'd2);
    check("sub_zero", 32'(Out_Zero), 32'd1);
    issue(4'd0, 16'h0100, '0, '0, 2'd1);
    check("add_pc_res", 32'(Out_Result), 32'h0102);
    check("b2b_valid", 32'(Out_Valid), 32'd1);

    issue(4'd10, 16'h8000, 16'h0004, '0, 2'd0);
    check("sra_res", 32'(Out_Result), 32'hF800);
    issue(4'd8, 16'h0001, 16'h0013, '0, 2'd0);
    check("sll_res", 32'(Out_Result), 32'h0008);
    issue(4'd7, 16'hFFFF, 16'h0001, '0, 2'd0);
    check("sltu_res", 32'(Out_Result), 32'd0);
    issue(4'd6, 16'hFFFF, 16'h0001, '0, 2'd0);
    check("slt_res", 32'(Out_Result), 32'd1);
    drain();

    // MUL -3*7 with spurious requests poked while busy.
    issue(4'd11, 16'hFFFD, 16'h0007, '0, 2'd0);
    for (int i = 0; i < W; i++) begin
      check("mul_busy", 32'(Out_Ready), 32'd0);
      drive(4'd0, 16'h1111, 16'h2222, '0, 2'd0);
      In_Valid = i[0];
      @(posedge CLK); #1;
    end
    In_Valid = 1'b0;
    check("mul_done_ready", 32'(Out_Ready), 32'd1);
    check("mul_done_valid", 32'(Out_Valid), 32'd1);
    check("mul_res", 32'(Out_Result), 32'hFFEB);
    drain();

    issue(4'd11, 16'd300, 16'd300, '0, 2'd0);
    issue(4'd11, 16'h0000, 16'h1234, '0, 2'd0);
    drain();
    check("mul0_zero", 32'(Out_Zero), 32'd1);

    // Reset in the middle of a multiply.
    start_unchecked_mul(16'h0123, 16'h0456);
    repeat (5) @(posedge CLK);
    #1 Reset = 1'b1;
    #1;
    check("mrst_result", 32'(Out_Result), 32'd0);
    check("mrst_zero",   32'(Out_Zero),   32'd1);
    check("mrst_ready",  32'(Out_Ready),  32'd1);
    check("mrst_valid",  32'(Out_Valid),  32'd0);
    @(posedge CLK); #1 Reset = 1'b0;
    model_last = '0;

    // Flush in the middle of a multiply keeps the previous result.
    issue(4'd3, 16'h1010, 16'h0101, '0, 2'd0);
    drain();
    start_unchecked_mul(16'h0042, 16'h0042);
    repeat (5) @(posedge CLK);
    #1 In_Flush = 1'b1;
    @(posedge CLK); #1 In_Flush = 1'b0;
    check("flush_ready",  32'(Out_Ready),  32'd1);
    check("flush_result", 32'(Out_Result), 32'(model_last));
    repeat (W + 2) @(posedge CLK);
    #1;
    check("flush_held", 32'(Out_Result), 32'(model_last));

    // Flush together with a request in IDLE: nothing accepted.
    drive(4'd0, 16'h0001, 16'h0001, '0, 2'd0);
    In_Flush = 1'b1;
    @(posedge CLK); #1;
    In_Flush = 1'b0; In_Valid = 1'b0;
    check("idle_flush_valid",  32'(Out_Valid),  32'd0);
    check("idle_flush_result", 32'(Out_Result), 32'(model_last));
    check("idle_flush_ready",  32'(Out_Ready),  32'd1);

    // Randomized mix, MUL weighted up so the multiplier sees many operand patterns.
    for (int i = 0; i < 200; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 4) == 0) ? 4'd11 : 4'($urandom_range(0, 15));
      issue(op, corner(), corner(), corner(), 2'($urandom_range(0, 3)));
    end
    drain();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
